// File: rtl/seg7_arb_pkg.sv
// Shared types and widths for the 7-segment display arbiter.
package seg7_arb_pkg;

    localparam int STATE_W = 2;
    localparam int NIB_W   = 4;
    localparam int DATA_W  = 4 * NIB_W;
    localparam int DP_W    = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/seg7_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
// The tick is not realigned to any external event.
module seg7_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count;

    // Count 0..TICK_DIV-1 and wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == CW'(TICK_DIV - 1)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == CW'(TICK_DIV - 1));

endmodule

// File: rtl/seg7_disp_arbiter.sv
// Round-robin arbiter time-sharing one 4-digit 7-segment display between
// NREQ sources, with a minimum hold window per owner and a blank gap
// between owners. Optional macro SEG7_ARB_PRIO0_EN makes requester 0
// urgent: it preempts any other owner or a running gap.
module seg7_disp_arbiter
    import seg7_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int TICK_DIV   = 100000,
    parameter int HOLD_TICKS = 2000,
    parameter int GAP_TICKS  = 100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic [NREQ*DP_W-1:0]   req_dp,
    output logic [NREQ-1:0]        grant,
    output logic [NIB_W-1:0]       dig0,
    output logic [NIB_W-1:0]       dig1,
    output logic [NIB_W-1:0]       dig2,
    output logic [NIB_W-1:0]       dig3,
    output logic [DP_W-1:0]        dp,
    output logic                   blank,
    output logic                   busy
);

    localparam int PW = $clog2(NREQ);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    arb_state_e        state, next_state;
    logic [NREQ-1:0]   next_grant;
    logic [PW-1:0]     ptr, next_ptr;
    logic [HW-1:0]     hold, next_hold;
    logic [GW-1:0]     gap, next_gap;
    logic [DATA_W-1:0] digits;
    logic [DP_W-1:0]   points;

    logic              tick;
    logic              win_any;
    logic [PW-1:0]     win_idx;
    logic              take_new;
    logic [PW-1:0]     sel_idx;
    logic              load_data;
    logic [PW-1:0]     data_idx;

    seg7_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    // Round-robin search starting just after the last owner; the last owner
    // itself is tried last so a lone requester can be re-granted.
    always_comb begin
        int j;
        j       = 0;
        win_any = 1'b0;
        win_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[j]) begin
                win_any = 1'b1;
                win_idx = PW'(j);
            end
        end
    end

    // Next-state logic: owner drop beats hold expiry; a counter loaded on a
    // transition ignores a tick arriving in the same cycle.
    always_comb begin
        next_state = state;
        next_grant = grant;
        next_ptr   = ptr;
        next_hold  = hold;
        next_gap   = gap;
        take_new   = 1'b0;
        sel_idx    = win_idx;
        load_data  = 1'b0;
        data_idx   = ptr;

        case (state)
            IDLE: begin
                if (win_any) begin
                    take_new = 1'b1;
                end
            end
            SHOW: begin
`ifdef SEG7_ARB_PRIO0_EN
                if (ptr != '0 && req[0]) begin
                    take_new = 1'b1;
                    sel_idx  = '0;
                end else
`endif
                if (!req[ptr]) begin
                    next_state = IDLE;
                    next_grant = '0;
                end else if (hold == '0 && (req & ~grant) != '0) begin
                    if (GAP_TICKS > 0) begin
                        next_state = GAP;
                        next_grant = '0;
                        next_gap   = GW'(GAP_TICKS);
                    end else begin
                        take_new = 1'b1;
                    end
                end else begin
                    load_data = 1'b1;
                    if (tick && hold != '0) begin
                        next_hold = hold - 1'b1;
                    end
                end
            end
            GAP: begin
`ifdef SEG7_ARB_PRIO0_EN
                if (req[0]) begin
                    take_new = 1'b1;
                    sel_idx  = '0;
                end else
`endif
                if (gap == '0) begin
                    if (win_any) begin
                        take_new = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end else if (tick) begin
                    next_gap = gap - 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                next_grant = '0;
            end
        endcase

        if (take_new) begin
            next_state = SHOW;
            next_grant = NREQ'(1) << sel_idx;
            next_ptr   = sel_idx;
            next_hold  = HW'(HOLD_TICKS);
            load_data  = 1'b1;
            data_idx   = sel_idx;
        end
    end

    // State, grant, counters and the displayed digit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            grant  <= '0;
            ptr    <= PW'(NREQ - 1);
            hold   <= '0;
            gap    <= '0;
            digits <= '0;
            points <= '0;
        end else begin
            state <= next_state;
            grant <= next_grant;
            ptr   <= next_ptr;
            hold  <= next_hold;
            gap   <= next_gap;
            if (load_data) begin
                digits <= req_data[DATA_W*int'(data_idx) +: DATA_W];
                points <= req_dp[DP_W*int'(data_idx) +: DP_W];
            end
        end
    end

    assign dig0  = digits[0*NIB_W +: NIB_W];
    assign dig1  = digits[1*NIB_W +: NIB_W];
    assign dig2  = digits[2*NIB_W +: NIB_W];
    assign dig3  = digits[3*NIB_W +: NIB_W];
    assign dp    = points;
    assign blank = (state != SHOW);
    assign busy  = (state == SHOW);

endmodule

// File: tb/tb_seg7_disp_arbiter.sv
// Self-checking bench for seg7_disp_arbiter: a cycle model of the arbitration
// rules plus directed scenarios with hand-computed literal expectations.
module tb_seg7_disp_arbiter;

    localparam int NREQ       = 3;
    localparam int TICK_DIV   = 4;
    localparam int HOLD_TICKS = 3;
    localparam int GAP_TICKS  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    req = '0;
    logic [47:0]   req_data = '0;
    logic [11:0]   req_dp = '0;
    logic [2:0]    grant;
    logic [3:0]    dig0, dig1, dig2, dig3, dp;
    logic          blank, busy;

    int checks = 0;
    int errors = 0;

    seg7_disp_arbiter #(
        .NREQ(NREQ), .TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS), .GAP_TICKS(GAP_TICKS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_dp(req_dp),
        .grant(grant), .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
        .dp(dp), .blank(blank), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model state: owner index (-1 = nobody), whether a gap is running.
    int          m_owner = -1;
    bit          m_in_gap = 0;
    int          m_ptr = NREQ - 1;
    int          m_hold = 0;
    int          m_gap = 0;
    int          m_edges = 0;
    bit          m_tick;
    logic [15:0] m_data = '0;
    logic [3:0]  m_dp = '0;

    function automatic int pick(input logic [2:0] r, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic modelGrant(input int w);
        m_owner  = w;
        m_ptr    = w;
        m_hold   = HOLD_TICKS;
        m_in_gap = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_in_gap = 0; m_ptr = NREQ - 1;
            m_hold = 0; m_gap = 0; m_edges = 0; m_data = '0; m_dp = '0;
        end else begin
            m_tick = (m_edges % TICK_DIV) == TICK_DIV - 1;
            m_edges++;
            if (m_owner >= 0) begin
`ifdef SEG7_ARB_PRIO0_EN
                if (m_owner != 0 && req[0]) modelGrant(0); else
`endif
                if (!req[m_owner]) m_owner = -1;
                else if (m_hold == 0 && (req & ~(3'b001 << m_owner)) != 0) begin
                    if (GAP_TICKS > 0) begin
                        m_owner = -1; m_in_gap = 1; m_gap = GAP_TICKS;
                    end else modelGrant(pick(req, m_ptr));
                end else if (m_tick && m_hold > 0) m_hold--;
            end else if (m_in_gap) begin
`ifdef SEG7_ARB_PRIO0_EN
                if (req[0]) modelGrant(0); else
`endif
                if (m_gap == 0) begin
                    m_in_gap = 0;
                    if (req != 0) modelGrant(pick(req, m_ptr));
                end else if (m_tick) m_gap--;
            end else if (req != 0) begin
                modelGrant(pick(req, m_ptr));
            end
            if (m_owner >= 0) begin
                m_data = req_data[16*m_owner +: 16];
                m_dp   = req_dp[4*m_owner +: 4];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic [15:0] d0, input logic [15:0] d1,
                                 input logic [15:0] d2, input logic [3:0] p0);
        req      = r;
        req_data = {d2, d1, d0};
        req_dp   = {4'h0, 4'h0, p0};
    endtask

    task automatic doReset(input logic [2:0] r, input logic [15:0] d0, input logic [15:0] d1,
                           input logic [15:0] d2);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(r, d0, d1, d2, 4'h0);
        rst_n = 1'b1;
    endtask

    task automatic tickWait();
        @(negedge clk);
        #2;
    endtask

    // Continuous comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            checkOutput("model_grant", {29'd0, grant}, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            checkOutput("model_blank", {31'd0, blank}, {31'd0, m_owner < 0});
            checkOutput("model_busy", {31'd0, busy}, {31'd0, m_owner >= 0});
            if (m_owner >= 0) begin
                checkOutput("model_digits", {16'd0, dig3, dig2, dig1, dig0}, {16'd0, m_data});
                checkOutput("model_dp", {28'd0, dp}, {28'd0, m_dp});
            end
        end
    end

    initial begin
        int owners[$];
        int lens[$];
        int gaps;
        int run;
        logic [2:0] prev;
        bit seen;

        // Reset values.
        repeat (3) @(negedge clk);
        #2;
        checkOutput("reset_grant", {29'd0, grant}, 32'd0);
        checkOutput("reset_blank", {31'd0, blank}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_digits", {16'd0, dig3, dig2, dig1, dig0}, 32'd0);

        // Sole requester gets the display next cycle and keeps it.
        applyStimulus(3'b001, 16'h1234, 16'h0, 16'h0, 4'h0);
        rst_n = 1'b1;
        tickWait();
        checkOutput("t1_grant", {29'd0, grant}, 32'h1);
        checkOutput("t1_blank", {31'd0, blank}, 32'd0);
        checkOutput("t1_digits", {16'd0, dig3, dig2, dig1, dig0}, 32'h1234);
        repeat (40) tickWait();
        checkOutput("t1_keep", {29'd0, grant}, 32'h1);

        // Live data update appears exactly one cycle later.
        applyStimulus(3'b001, 16'h0000, 16'h0, 16'h0, 4'h0);
        tickWait();
        @(negedge clk);
        applyStimulus(3'b001, 16'hBEEF, 16'h0, 16'h0, 4'b1010);
        #2;
        checkOutput("t4_before", {16'd0, dig3, dig2, dig1, dig0}, 32'h0000);
        tickWait();
        checkOutput("t4_digits", {16'd0, dig3, dig2, dig1, dig0}, 32'hBEEF);
        checkOutput("t4_dp", {28'd0, dp}, 32'hA);

        // All three requesting: round-robin with gaps.
        doReset(3'b111, 16'h1111, 16'h2222, 16'h3333);
        prev = '0; run = 0; gaps = 0;
        for (int c = 0; c < 200 && owners.size() < 4; c++) begin
            tickWait();
            if (grant != prev) begin
                if (prev != 0) lens.push_back(run);
                if (grant != 0) owners.push_back(int'(grant));
                else gaps++;
                run = 0;
                prev = grant;
            end
            if (grant != 0) run++;
        end
        checkOutput("t2_count", owners.size(), 32'd4);
        if (owners.size() == 4) begin
            checkOutput("t2_owner0", owners[0], 32'h1);
            checkOutput("t2_owner1", owners[1], 32'h2);
            checkOutput("t2_owner2", owners[2], 32'h4);
            checkOutput("t2_owner3", owners[3], 32'h1);
            checkOutput("t2_gaps", gaps, 32'd3);
            for (int i = 0; i < 3; i++) begin
                checkOutput("t2_len_ok", {31'd0, (lens[i] >= 9 && lens[i] <= 16)}, 32'd1);
            end
        end

        // Owner 1 drops mid-hold: idle for one cycle, then requester 2 with no gap.
        doReset(3'b010, 16'h0, 16'hC0DE, 16'h5678);
        tickWait();
        checkOutput("t3_grant1", {29'd0, grant}, 32'h2);
        @(negedge clk);
        applyStimulus(3'b110, 16'h0, 16'hC0DE, 16'h5678, 4'h0);
        @(negedge clk);
        applyStimulus(3'b100, 16'h0, 16'hC0DE, 16'h5678, 4'h0);
        tickWait();
        checkOutput("t3_idle_grant", {29'd0, grant}, 32'h0);
        checkOutput("t3_idle_blank", {31'd0, blank}, 32'd1);
        tickWait();
        checkOutput("t3_grant2", {29'd0, grant}, 32'h4);
        checkOutput("t3_blank", {31'd0, blank}, 32'd0);

        // Owner 2 in SHOW, requester 0 rises.
        doReset(3'b100, 16'h0, 16'h0, 16'h5678);
        tickWait();
        @(negedge clk);
        applyStimulus(3'b101, 16'h9ABC, 16'h0, 16'h5678, 4'h0);
        tickWait();
`ifdef SEG7_ARB_PRIO0_EN
        checkOutput("t6_preempt", {29'd0, grant}, 32'h1);
        checkOutput("t6_noblank", {31'd0, blank}, 32'd0);
`else
        checkOutput("t6_keep", {29'd0, grant}, 32'h4);
`endif

        // Reset pulsed during a gap.
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tickWait();
            if (blank) seen = 1;
        end
        checkOutput("t5_reached_gap", {31'd0, seen}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_grant", {29'd0, grant}, 32'h0);
        checkOutput("t5_blank", {31'd0, blank}, 32'd1);
        checkOutput("t5_busy", {31'd0, busy}, 32'd0);
        checkOutput("t5_digits", {12'd0, dp, dig3, dig2, dig1, dig0}, 32'h0);
        repeat (2) @(negedge clk);
        applyStimulus(3'b111, 16'h4321, 16'h0, 16'h0, 4'h0);
        rst_n = 1'b1;
        tickWait();
        checkOutput("t5_restart", {29'd0, grant}, 32'h1);
        checkOutput("t5_restart_dig", {16'd0, dig3, dig2, dig1, dig0}, 32'h4321);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
